// File: rtl/hamming_pkg.sv
// Shared Hamming code helpers: check-bit count from data width, power-of-two
// test, codeword-position to data-index mapping, and the decode classification.
package hamming_pkg;

  typedef enum logic [1:0] {
    DEC_CLEAN  = 2'd0,
    DEC_CORR   = 2'd1,
    DEC_UNCORR = 2'd2
  } dec_class_e;

  // Smallest r with 2^r >= k + r + 1.
  function automatic int unsigned calc_r(input int unsigned k);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 31; i++) begin
      if (r == 0 && (32'(1) << i) >= k + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Data index held at a non-power-of-two position (position 3 -> index 0).
  function automatic int unsigned pos_to_didx(input int unsigned pos);
    int unsigned np;
    np = 0;
    for (int unsigned b = 0; b < 31; b++) begin
      if ((32'(1) << b) <= pos) np = np + 1;
    end
    return pos - np - 1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity.
//   code : codeword, bit i-1 is position i
//   s    : XOR of indices of all set positions 1..N
//   p    : XOR of all W bits
module hamming_syndrome #(
  parameter int unsigned R = 4,
  parameter int unsigned N = 15,
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] code,
  output logic [R-1:0] s,
  output logic         p
);

  always_comb begin
    s = '0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if (code[pos-1]) s = s ^ R'(pos);
    end
  end

  assign p = ^code;

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage pipelined Hamming SEC / SECDED decoder with error counters.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_code     : input codeword handshake
//   out_valid/out_ready/out_data  : decoded result handshake
//   out_corr/out_uncorr/out_pos   : classification, corrected position
//   correct_en                    : 0 = flag errors but pass raw data
//   cnt_clr/cnt_corr/cnt_uncorr   : saturating error counters
module hamming_secded_dec_pipe
  import hamming_pkg::*;
#(
  parameter  int unsigned K      = 11,
  parameter  int unsigned SECDED = 1,
  parameter  int unsigned CW     = 16,
  localparam int unsigned R      = calc_r(K),
  localparam int unsigned N      = K + R,
  localparam int unsigned W      = N + SECDED
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_data,
  output logic          out_corr,
  output logic          out_uncorr,
  output logic [R-1:0]  out_pos,
  input  logic          correct_en,
  input  logic          cnt_clr,
  output logic [CW-1:0] cnt_corr,
  output logic [CW-1:0] cnt_uncorr
);

  // Whole pipeline advances together unless the output is blocked.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic [R-1:0] syn_s;
  logic         syn_p;

  hamming_syndrome #(.R(R), .N(N), .W(W)) u_syn (
    .code (in_code),
    .s    (syn_s),
    .p    (syn_p)
  );

  // Stage 1: syndrome, parity, raw positions 1..N and the correction enable.
  logic         s1_valid;
  logic [N-1:0] s1_code;
  logic [R-1:0] s1_s;
  logic         s1_p;
  logic         s1_cen;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_s     <= '0;
      s1_p     <= 1'b0;
      s1_cen   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code[N-1:0];
        s1_s    <= syn_s;
        s1_p    <= syn_p;
        s1_cen  <= correct_en;
      end
    end
  end

  // Classification and correction of the stage-1 word.
  dec_class_e   cls;
  logic         s_in_range;
  logic         fix;
  logic [K-1:0] dec_data;
  logic [R-1:0] dec_pos;

  always_comb begin
    cls        = DEC_CLEAN;
    s_in_range = (32'(s1_s) <= N);
    if (SECDED != 0) begin
      if (s1_s == '0 && !s1_p)     cls = DEC_CLEAN;
      else if (s1_p && s_in_range) cls = DEC_CORR;
      else                         cls = DEC_UNCORR;
    end else begin
      if (s1_s == '0)      cls = DEC_CLEAN;
      else if (s_in_range) cls = DEC_CORR;
      else                 cls = DEC_UNCORR;
    end
    // s is 0 for an overall-parity hit, so out_pos reports 0 there.
    dec_pos = (cls == DEC_CORR) ? s1_s : '0;
    fix     = (cls == DEC_CORR) && s1_cen;
    dec_data = '0;
    for (int unsigned pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) begin
        dec_data[pos_to_didx(pos)] = s1_code[pos-1] ^ (fix && (s1_s == R'(pos)));
      end
    end
  end

  // Stage 2: registered result, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
      out_pos    <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data   <= dec_data;
        out_corr   <= (cls == DEC_CORR);
        out_uncorr <= (cls == DEC_UNCORR);
        out_pos    <= dec_pos;
      end
    end
  end

  // Saturating counters on output transfers; clear wins over increment.
  logic xfer;
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (xfer) begin
      if (out_corr && cnt_corr != '1)     cnt_corr   <= cnt_corr + CW'(1);
      if (out_uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + CW'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Directed bench: instance A is K=11 SECDED, instance B is K=11 plain SEC with
// a 2-bit counter so saturation is reachable in a few words.
module tb_hamming_secded_dec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic        a_corr, a_uncorr, a_cen, a_clr;
  logic [15:0] a_code;
  logic [10:0] a_data;
  logic [3:0]  a_pos;
  logic [15:0] a_cc, a_cu;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic        b_corr, b_uncorr, b_cen, b_clr;
  logic [14:0] b_code;
  logic [10:0] b_data;
  logic [3:0]  b_pos;
  logic [1:0]  b_cc, b_cu;

  hamming_secded_dec_pipe #(.K(11), .SECDED(1), .CW(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_data),
    .out_corr(a_corr), .out_uncorr(a_uncorr), .out_pos(a_pos),
    .correct_en(a_cen), .cnt_clr(a_clr), .cnt_corr(a_cc), .cnt_uncorr(a_cu)
  );

  hamming_secded_dec_pipe #(.K(11), .SECDED(0), .CW(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_data),
    .out_corr(b_corr), .out_uncorr(b_uncorr), .out_pos(b_pos),
    .correct_en(b_cen), .cnt_clr(b_clr), .cnt_corr(b_cc), .cnt_uncorr(b_cu)
  );

  int total = 0;
  int bad   = 0;
  logic [10:0] rx[$];
  logic [10:0] exp_stream [4] = '{11'h001, 11'h002, 11'h003, 11'h000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records an output transfer that will happen at the coming edge.
  task automatic step();
    if (a_out_valid && a_out_ready) rx.push_back(a_data);
    tick();
  endtask

  task automatic send_a(input string tag, input logic [15:0] code, input logic [10:0] ed,
                        input logic ec, input logic eu, input logic [3:0] ep);
    chk({tag, ".rdy"}, 32'(a_in_ready), 32'd1);
    a_code = code; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(a_out_valid), 32'd0);
    tick();
    chk({tag, ".lat2"}, 32'(a_out_valid), 32'd1);
    chk({tag, ".data"}, 32'(a_data), 32'(ed));
    chk({tag, ".corr"}, 32'(a_corr), 32'(ec));
    chk({tag, ".uncorr"}, 32'(a_uncorr), 32'(eu));
    chk({tag, ".pos"}, 32'(a_pos), 32'(ep));
    tick();
  endtask

  task automatic send_b(input string tag, input logic [14:0] code, input logic cen,
                        input logic [10:0] ed, input logic ec, input logic [3:0] ep);
    b_code = code; b_cen = cen; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk({tag, ".vld"}, 32'(b_out_valid), 32'd1);
    chk({tag, ".data"}, 32'(b_data), 32'(ed));
    chk({tag, ".corr"}, 32'(b_corr), 32'(ec));
    chk({tag, ".uncorr"}, 32'(b_uncorr), 32'd0);
    chk({tag, ".pos"}, 32'(b_pos), 32'(ep));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_cen = 1'b1; a_clr = 1'b0; a_code = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_cen = 1'b1; b_clr = 1'b0; b_code = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst.vld", 32'(a_out_valid), 32'd0);
    chk("rst.data", 32'(a_data), 32'd0);
    chk("rst.corr", 32'(a_corr), 32'd0);
    chk("rst.uncorr", 32'(a_uncorr), 32'd0);
    chk("rst.pos", 32'(a_pos), 32'd0);
    chk("rst.cc", 32'(a_cc), 32'd0);
    chk("rst.cu", 32'(a_cu), 32'd0);
    chk("rst.rdy", 32'(a_in_ready), 32'd1);
    chk("rst.b_vld", 32'(b_out_valid), 32'd0);

    send_a("clean0", 16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);
    chk("clean0.cc", 32'(a_cc), 32'd0);
    send_a("pos5", 16'h0010, 11'h000, 1'b1, 1'b0, 4'd5);
    chk("pos5.cc", 32'(a_cc), 32'd1);
    send_a("dbl35", 16'h0014, 11'h003, 1'b0, 1'b1, 4'd0);
    chk("dbl35.cu", 32'(a_cu), 32'd1);
    send_a("ovr", 16'h8000, 11'h000, 1'b1, 1'b0, 4'd0);
    chk("ovr.cc", 32'(a_cc), 32'd2);
    send_a("clean1", 16'h8007, 11'h001, 1'b0, 1'b0, 4'd0);
    send_a("pos7", 16'h8047, 11'h001, 1'b1, 1'b0, 4'd7);
    chk("pos7.cc", 32'(a_cc), 32'd3);
    chk("pos7.cu", 32'(a_cu), 32'd1);

    // Back-to-back stream with a 3-cycle output stall.
    rx.delete();
    a_code = 16'h8007; a_in_valid = 1'b1;
    step();
    a_code = 16'h8019;
    step();
    a_out_ready = 1'b0; a_code = 16'h001E;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall.rdy", 32'(a_in_ready), 32'd0);
      chk("stall.vld", 32'(a_out_valid), 32'd1);
      chk("stall.data", 32'(a_data), 32'h001);
      chk("stall.corr", 32'(a_corr), 32'd0);
      step();
    end
    a_out_ready = 1'b1;
    step();
    a_code = 16'h0000;
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 8 && rx.size() < 4; i++) step();
    chk("stream.count", 32'(rx.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("stream.word", (i < rx.size()) ? 32'(rx[i]) : 32'hdead_beef, 32'(exp_stream[i]));
    end
    chk("stream.drain", 32'(a_out_valid), 32'd0);

    // Plain SEC instance: correct_en behaviour and counter saturation.
    send_b("b_p4", 15'h000F, 1'b1, 11'h001, 1'b1, 4'd4);
    chk("b_p4.cc", 32'(b_cc), 32'd1);
    send_b("b_p4_nocor", 15'h000F, 1'b0, 11'h001, 1'b1, 4'd4);
    chk("b_p4_nocor.cc", 32'(b_cc), 32'd2);
    send_b("b_d0", 15'h0004, 1'b1, 11'h000, 1'b1, 4'd3);
    chk("b_d0.cc", 32'(b_cc), 32'd3);
    send_b("b_d0_nocor", 15'h0004, 1'b0, 11'h001, 1'b1, 4'd3);
    chk("b_sat.cc", 32'(b_cc), 32'd3);

    // Clear on the same edge as a corrected-word transfer.
    b_code = 15'h0004; b_cen = 1'b1; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk("clr.vld", 32'(b_out_valid), 32'd1);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("clr.cc", 32'(b_cc), 32'd0);
    chk("clr.cu", 32'(b_cu), 32'd0);
    tick();
    chk("clr.cc_hold", 32'(b_cc), 32'd0);

    // Reset with a word in flight discards it.
    chk("mid.cc_pre", 32'(a_cc), 32'd3);
    a_code = 16'h0010; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid.vld", 32'(a_out_valid), 32'd0);
      tick();
    end
    chk("mid.cc", 32'(a_cc), 32'd0);
    chk("mid.rdy", 32'(a_in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_secded_dec_pipe.md
HAMMING_SECDED_DEC_PIPE -- requirements
Module: hamming_secded_dec_pipe

Interface
REQ-001 SHALL have parameter K, default 11, number of data bits (K >= 4).
REQ-002 SHALL have parameter SECDED, default 1, where 1 adds an overall-parity bit (SECDED) and 0 is plain Hamming SEC.
REQ-003 SHALL have parameter CW, default 16, error-counter width.
REQ-004 SHALL derive localparam R as the smallest R with 2^R >= K+R+1, N = K+R, and W = N+SECDED.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports in_valid  in  1, in_ready  out  1, in_code  in  W, forming the input codeword handshake.
REQ-008 SHALL have ports out_valid  out  1, out_ready  in  1, out_data  out  K, forming the decoded result handshake.
REQ-009 SHALL have ports out_corr  out  1 (single error corrected), out_uncorr  out  1 (uncorrectable), out_pos  out  R (corrected position, 0 = none or overall bit).
REQ-010 SHALL have port correct_en  in  1; when it is 0, errors are flagged but data is not modified.
REQ-011 SHALL have ports cnt_clr  in  1, cnt_corr  out  CW, cnt_uncorr  out  CW.

Function
REQ-012 SHALL map in_code bit i-1 to codeword position i (1..N), with parity bits at power-of-two positions; bit N is the overall parity when SECDED=1.
REQ-013 SHALL map data bits to the non-power-of-two positions in ascending order, so that out_data[0] is position 3.
REQ-014 SHALL compute syndrome s as the XOR of the indices of all set positions 1..N, and p as the XOR of all W bits.
REQ-015 SECDED=1 classification SHALL be:
  - s=0, p=0: clean.
  - s!=0, p=1, s<=N: corrected at position s.
  - s=0, p=1: corrected, overall bit, out_pos=0, data unchanged.
  - s!=0, p=0, or s>N: uncorrectable.
REQ-016 SECDED=0 classification SHALL be:
  - s=0: clean.
  - s in 1..N: corrected.
  - s>N: uncorrectable.
REQ-017 On uncorrectable, or when correct_en=0, out_data SHALL carry the raw extracted data bits; out_corr and out_uncorr are never both 1.
REQ-018 SHALL be a two-stage pipeline (S1 registers syndrome/parity/raw word, S2 registers corrected result); latency is 2 cycles from accepted input to out_valid.
REQ-019 A transfer SHALL occur when valid&&ready on the same rising edge.
REQ-020 in_ready SHALL equal !(out_valid && !out_ready); the whole pipeline stalls together and no result is dropped or duplicated.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_corr, out_uncorr and out_pos SHALL hold stable.
REQ-022 Full throughput SHALL be one codeword per cycle when out_ready=1.
REQ-023 cnt_corr and cnt_uncorr SHALL increment by 1 on each output transfer flagged as corrected or uncorrectable respectively, saturating at 2^CW-1.
REQ-024 cnt_clr SHALL zero both counters next cycle and take priority over a simultaneous increment.

Reset
REQ-025 On rst=1 at a clock edge, both pipeline stages SHALL become empty.
REQ-026 The same reset SHALL set out_valid=0, out_data=0, out_corr=0, out_uncorr=0, out_pos=0, cnt_corr=0 and cnt_uncorr=0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset.
REQ-028 Reset mid-stream SHALL discard in-flight words without counting them.

Structure
REQ-029 SHALL place the R-from-K function, the is_pow2 function and the position-to-data-index mapping function in a shared package hamming_pkg.
REQ-030 SHALL instantiate one combinational sub-module hamming_syndrome (codeword in; s, p out), reusable by a future encoder check.

Verification
REQ-031 With K=11 and SECDED=1, in_code=16'h0000 SHALL give out_data=11'h000, corr=0, uncorr=0, out_valid 2 cycles after acceptance.
REQ-032 With K=11 and SECDED=1, in_code=16'h0010 (position 5 flipped) SHALL give out_data=11'h000, corr=1, out_pos=5, and cnt_corr=1.
REQ-033 With K=11 and SECDED=1, in_code=16'h0014 (positions 3 and 5 flipped) SHALL give uncorr=1, out_data=11'h003, and cnt_uncorr=1.
REQ-034 With K=11 and SECDED=1, in_code=16'h8000 (overall parity bit only) SHALL give corr=1, out_pos=0, out_data=11'h000.
REQ-035 With K=11 and SECDED=0, in_code=15'h000F SHALL give corr=1, out_pos=4, out_data=11'h001; the same input with correct_en=0 SHALL give out_data=11'h001 and corr=1.
REQ-036 Back-to-back stream with out_ready held low for 3 cycles SHALL keep outputs stable and in_ready=0 while stalled.
REQ-037 After the stall, all words SHALL emerge in order with none lost.
REQ-038 Forcing cnt_corr to 2^CW-1 and sending another correctable word SHALL leave it saturated; cnt_clr with a simultaneous event SHALL yield 0.
